// File: rtl/axi_perf_sched_if.sv
// Signal bundle between the UART command front end, the performance
// scheduler and the AXI traffic generator.
//
// Handshakes (cmd_*, burst_*, res_*): a transfer happens on a rising clock
// edge where valid and ready are both 1. Once valid is raised, the payload
// stays stable and valid stays high until that transfer. ready may be driven
// independently of valid. burst_done is a single-cycle pulse with no ready.
interface axi_perf_sched_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int STAT_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_mode;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [CNT_WIDTH-1:0]  cmd_bursts;

    logic                  burst_valid;
    logic                  burst_ready;
    logic                  burst_write;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  burst_done;

    logic                  res_valid;
    logic                  res_ready;
    logic [STAT_WIDTH-1:0] res_wr_cycles;
    logic [STAT_WIDTH-1:0] res_rd_cycles;
    logic                  res_err;

    // Scheduler FSM state, exported for checkers (0 idle, 1 wr, 2 rd, 3 report)
    logic [1:0]            dbg_state;

    // Scheduler side
    modport master (
        input  cmd_valid, cmd_mode, cmd_addr, cmd_len, cmd_bursts,
        output cmd_ready,
        output burst_valid, burst_write, burst_addr, burst_len,
        input  burst_ready, burst_done,
        output res_valid, res_wr_cycles, res_rd_cycles, res_err,
        input  res_ready,
        output dbg_state
    );

    // Front end / traffic generator side
    modport slave (
        output cmd_valid, cmd_mode, cmd_addr, cmd_len, cmd_bursts,
        input  cmd_ready,
        input  burst_valid, burst_write, burst_addr, burst_len,
        output burst_ready, burst_done,
        input  res_valid, res_wr_cycles, res_rd_cycles, res_err,
        output res_ready,
        input  dbg_state
    );
endinterface

// File: rtl/axi_perf_sched.sv
// AXI memory performance scheduler: takes one test command, issues a run of
// fixed-length bursts with a cap on bursts in flight, times the write and/or
// read phase, and hands back one result record per command.
module axi_perf_sched #(
    parameter int ADDR_WIDTH      = 16,
    parameter int LEN_WIDTH       = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int STAT_WIDTH      = 16,
    parameter int BEAT_BYTES      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_perf_sched_if.master bus
);
    // Wide enough for MAX_OUTSTANDING up to 15 plus a same-cycle increment
    localparam int OUT_W      = 5;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state, state_next;

    logic                  cmd_ready_q;
    logic                  burst_valid_q;
    logic                  burst_write_q;
    logic [ADDR_WIDTH-1:0] burst_addr_q;
    logic [LEN_WIDTH-1:0]  burst_len_q;
    logic                  res_valid_q;
    logic [STAT_WIDTH-1:0] wr_cnt_q;
    logic [STAT_WIDTH-1:0] rd_cnt_q;
    logic                  err_q;

    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  bursts_q;
    logic [ADDR_WIDTH-1:0] addr_q;      // address of the next burst to present
    logic [CNT_WIDTH-1:0]  issued_q;    // bursts presented in this phase
    logic [OUT_W-1:0]      out_q;       // bursts accepted but not yet done

    logic                  cmd_fire;
    logic                  burst_acc;
    logic                  in_phase;
    logic                  issue;
    logic                  phase_end;
    logic                  spurious;
    logic [OUT_W-1:0]      out_next;
    logic [ADDR_WIDTH-1:0] addr_step;

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.burst_valid   = burst_valid_q;
    assign bus.burst_write   = burst_write_q;
    assign bus.burst_addr    = burst_addr_q;
    assign bus.burst_len     = burst_len_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_wr_cycles = wr_cnt_q;
    assign bus.res_rd_cycles = rd_cnt_q;
    assign bus.res_err       = err_q;
    assign bus.dbg_state     = state;

    assign cmd_fire  = (state == IDLE) && cmd_ready_q && bus.cmd_valid;
    assign burst_acc = burst_valid_q && bus.burst_ready;
    assign in_phase  = (state == WR) || (state == RD);
    // Burst footprint in bytes; wraps silently at the top of the address space
    assign addr_step = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << BEAT_SHIFT;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state plus in-flight accounting, issue and phase-end decisions
    always_comb begin
        state_next = state;
        out_next   = out_q;
        issue      = 1'b0;
        phase_end  = 1'b0;
        spurious   = 1'b0;

        if (in_phase) begin
            if (burst_acc && !bus.burst_done) begin
                out_next = out_q + OUT_W'(1);
            end else if (!burst_acc && bus.burst_done) begin
                if (out_q == '0) spurious = 1'b1;
                else             out_next = out_q - OUT_W'(1);
            end
            // A presented burst that is accepted this cycle frees the slot,
            // so the next one can follow back-to-back.
            issue = (issued_q < bursts_q) && (!burst_valid_q || bus.burst_ready) &&
                    (out_next < OUT_W'(MAX_OUTSTANDING));
            phase_end = (issued_q == bursts_q) && (out_next == '0) && !burst_valid_q;
        end

        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    case (bus.cmd_mode)
                        2'b01, 2'b11: state_next = WR;
                        2'b10:        state_next = RD;
                        default:      state_next = REPORT;
                    endcase
                end
            end
            WR:      if (phase_end) state_next = (mode_q == 2'b11) ? RD : REPORT;
            RD:      if (phase_end) state_next = REPORT;
            REPORT:  if (res_valid_q && bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, command latch, burst issue and phase timers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q   <= 1'b0;
            burst_valid_q <= 1'b0;
            burst_write_q <= 1'b0;
            burst_addr_q  <= '0;
            burst_len_q   <= '0;
            res_valid_q   <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            err_q         <= 1'b0;
            mode_q        <= '0;
            base_q        <= '0;
            len_q         <= '0;
            bursts_q      <= '0;
            addr_q        <= '0;
            issued_q      <= '0;
            out_q         <= '0;
        end else begin
            cmd_ready_q   <= (state_next == IDLE);
            res_valid_q   <= (state_next == REPORT);
            burst_write_q <= (state_next == WR);

            if (cmd_fire) begin
                mode_q        <= bus.cmd_mode;
                base_q        <= bus.cmd_addr;
                len_q         <= bus.cmd_len;
                bursts_q      <= bus.cmd_bursts;
                addr_q        <= bus.cmd_addr;
                issued_q      <= '0;
                out_q         <= '0;
                wr_cnt_q      <= '0;
                rd_cnt_q      <= '0;
                err_q         <= 1'b0;
                burst_valid_q <= 1'b0;
            end else if (in_phase) begin
                out_q <= out_next;
                if (spurious) err_q <= 1'b1;

                if (issue) begin
                    burst_valid_q <= 1'b1;
                    burst_addr_q  <= addr_q;
                    burst_len_q   <= len_q;
                    addr_q        <= addr_q + addr_step;
                    issued_q      <= issued_q + CNT_WIDTH'(1);
                end else if (burst_acc) begin
                    burst_valid_q <= 1'b0;
                end

                // An empty phase ends on entry and reports zero cycles
                if (bursts_q != '0) begin
                    if (state == WR && wr_cnt_q != {STAT_WIDTH{1'b1}})
                        wr_cnt_q <= wr_cnt_q + STAT_WIDTH'(1);
                    if (state == RD && rd_cnt_q != {STAT_WIDTH{1'b1}})
                        rd_cnt_q <= rd_cnt_q + STAT_WIDTH'(1);
                end

                // Read phase restarts at the command address
                if (phase_end) begin
                    addr_q   <= base_q;
                    issued_q <= '0;
                    out_q    <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_perf_sched.sv
// Directed bench for axi_perf_sched: write, write+read with the in-flight
// cap, address wrap, stalled ready, empty commands, stray completions and
// reset in the middle of a phase.
module tb_axi_perf_sched;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    axi_perf_sched_if bus ();

    axi_perf_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Captured accepts and the expected address list
    logic [15:0] exp_q[$];
    logic [15:0] acc_addr_q[$];
    logic [7:0]  acc_len_q[$];
    logic        acc_wr_q[$];
    int          owed;
    bit          release_done;
    bit          saw_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        acc_addr_q.delete();
        acc_len_q.delete();
        acc_wr_q.delete();
        owed      = 0;
        saw_valid = 0;
    endtask

    // One cycle of the traffic-generator model, called at a falling edge:
    // completes one owed burst per cycle when released, records accepts.
    task automatic step();
        bus.burst_done = release_done && (owed > 0);
        if (release_done && owed > 0) owed--;
        if (bus.burst_valid) saw_valid = 1;
        if (bus.burst_valid && bus.burst_ready) begin
            acc_addr_q.push_back(bus.burst_addr);
            acc_len_q.push_back(bus.burst_len);
            acc_wr_q.push_back(bus.burst_write);
            owed++;
        end
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic [15:0] addr,
                            input logic [7:0] len, input logic [15:0] bursts);
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_mode   = mode;
        bus.cmd_addr   = addr;
        bus.cmd_len    = len;
        bus.cmd_bursts = bursts;
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic run_until_result(input int budget);
        for (int i = 0; i < budget && !bus.res_valid; i++) step();
        bus.burst_done = 1'b0;
    endtask

    task automatic check_result(input string tag, input int wr, input int rd, input int err);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 1);
        check({tag, "_wr_cycles"}, 32'(bus.res_wr_cycles), 32'(wr));
        check({tag, "_rd_cycles"}, 32'(bus.res_rd_cycles), 32'(rd));
        check({tag, "_err"}, 32'(bus.res_err), 32'(err));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_cmd_ready_after"}, 32'(bus.cmd_ready), 1);
        check({tag, "_res_valid_after"}, 32'(bus.res_valid), 0);
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_count"}, 32'(acc_addr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_addr_q.size(); i++)
            check(tag, 32'(acc_addr_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        check({tag, "_burst_valid"}, 32'(bus.burst_valid), 0);
        check({tag, "_burst_write"}, 32'(bus.burst_write), 0);
        check({tag, "_burst_addr"}, 32'(bus.burst_addr), 0);
        check({tag, "_burst_len"}, 32'(bus.burst_len), 0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_res_wr"}, 32'(bus.res_wr_cycles), 0);
        check({tag, "_res_rd"}, 32'(bus.res_rd_cycles), 0);
        check({tag, "_res_err"}, 32'(bus.res_err), 0);
        check({tag, "_state"}, 32'(bus.dbg_state), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        release_done = 0;
        clear_capture();
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_mode   = 2'b00;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.cmd_bursts = '0;
        bus.burst_ready = 1'b0;
        bus.burst_done  = 1'b0;
        bus.res_ready   = 1'b0;

        // Reset values, then ready on the first clock after release
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("por_ready_after_release", 32'(bus.cmd_ready), 1);

        // Write only, one burst, completion one cycle after accept
        clear_capture();
        bus.burst_ready = 1'b1;
        release_done    = 1;
        send_cmd(2'b01, 16'h0100, 8'd3, 16'd1);
        run_until_result(100);
        exp_q = '{16'h0100};
        check_addrs("t1_addr");
        if (acc_len_q.size() > 0) begin
            check("t1_len", 32'(acc_len_q[0]), 3);
            check("t1_write", 32'(acc_wr_q[0]), 1);
        end
        check_result("t1", 3, 0, 0);

        // Write then read, 6 bursts, cap of 4 in flight with completions withheld
        clear_capture();
        release_done = 0;
        send_cmd(2'b11, 16'h0000, 8'd7, 16'd6);
        repeat (10) step();
        exp_q = '{16'h0000, 16'h0020, 16'h0040, 16'h0060};
        check_addrs("t2_stall");
        check("t2_stall_valid", 32'(bus.burst_valid), 0);
        check("t2_stall_write", 32'(bus.burst_write), 1);
        release_done = 1;
        run_until_result(200);
        exp_q = '{16'h0000, 16'h0020, 16'h0040, 16'h0060, 16'h0080, 16'h00A0,
                  16'h0000, 16'h0020, 16'h0040, 16'h0060, 16'h0080, 16'h00A0};
        check_addrs("t2_all");
        for (int i = 0; i < acc_wr_q.size(); i++)
            check("t2_write", 32'(acc_wr_q[i]), (i < 6) ? 1 : 0);
        check_result("t2", 16, 8, 0);

        // Address wrap at the top of the space
        clear_capture();
        send_cmd(2'b01, 16'hFFF0, 8'd3, 16'd3);
        run_until_result(100);
        exp_q = '{16'hFFF0, 16'h0000, 16'h0010};
        check_addrs("t3_wrap");
        check_result("t3", 5, 0, 0);

        // Ready held low for 5 cycles: payload and valid must hold
        clear_capture();
        bus.burst_ready = 1'b0;
        send_cmd(2'b01, 16'h0200, 8'd1, 16'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(bus.burst_valid), 1);
            check("t4_hold_addr", 32'(bus.burst_addr), 32'h0200);
            check("t4_hold_len", 32'(bus.burst_len), 1);
            step();
        end
        bus.burst_ready = 1'b1;
        run_until_result(100);
        exp_q = '{16'h0200};
        check_addrs("t4_addr");
        check_result("t4", 8, 0, 0);

        // Completion with nothing outstanding sets the sticky error
        clear_capture();
        send_cmd(2'b01, 16'h0300, 8'd0, 16'd1);
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        run_until_result(100);
        check_result("t5", 3, 0, 1);

        // No-op command: no bursts, zero counts, error cleared by new command
        clear_capture();
        send_cmd(2'b00, 16'h1234, 8'd5, 16'd5);
        run_until_result(100);
        check("t6_no_valid", 32'(saw_valid), 0);
        check_result("t6", 0, 0, 0);

        // Zero bursts in both phases
        clear_capture();
        send_cmd(2'b11, 16'h0000, 8'd3, 16'd0);
        run_until_result(100);
        check("t7_no_valid", 32'(saw_valid), 0);
        check_result("t7", 0, 0, 0);

        // Zero-burst read phase with a stray completion on its only cycle
        clear_capture();
        send_cmd(2'b10, 16'h0000, 8'd3, 16'd0);
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        run_until_result(100);
        check("t8_no_valid", 32'(saw_valid), 0);
        check_result("t8", 0, 0, 1);

        // Reset with two bursts in flight, late completion while idle
        clear_capture();
        release_done = 0;
        send_cmd(2'b01, 16'h0000, 8'd0, 16'd4);
        repeat (3) step();
        check("t9_inflight", 32'(acc_addr_q.size()), 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t9_rst");
        @(negedge clk);
        bus.burst_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        check("t9_ready_after_release", 32'(bus.cmd_ready), 1);
        check("t9_err_after_late_done", 32'(bus.res_err), 0);
        clear_capture();
        release_done = 1;
        send_cmd(2'b01, 16'h0040, 8'd0, 16'd2);
        run_until_result(100);
        exp_q = '{16'h0040, 16'h0044};
        check_addrs("t9_new");
        check_result("t9_new", 4, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
